// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared constants and the pipeline stage record used by the
//                16-bit, 4-stage carry-lookahead pipelined adder.
//  Contents    : NIB_W   - bits added per stage
//                NUM_STG - number of pipeline stages
//                DATA_W  - operand / sum width
//                stage_t - one pipeline slot
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  localparam int NIB_W    = 4;
  localparam int NUM_STG  = 4;
  localparam int DATA_W   = NIB_W * NUM_STG;
  localparam int LAST_STG = NUM_STG - 1;

  // One slot of the pipe. Entering stage k, nibbles 0..k-1 of psum are
  // complete and rem_a/rem_b have been shifted so that the nibble stage k
  // must add sits in bits [NIB_W-1:0]. An invalid slot is kept all-zero.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] psum;
    logic              carry;
    logic [DATA_W-1:0] rem_a;
    logic [DATA_W-1:0] rem_b;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/cla_slice4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_slice4
//  Description : Combinational 4-bit carry-lookahead adder slice. All carries
//                are written as fully expanded sum-of-products of generate and
//                propagate terms, so nothing ripples inside the nibble.
//  Ports       : a, b  - nibble operands
//                ci    - carry into bit 0
//                s     - nibble sum
//                co    - carry out of bit 3
//                c3    - carry into bit 3 (used for signed overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_slice4
  import cla_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic             c1;
  logic             c2;

  assign g = a & b;
  assign p = a | b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  // With p = a|b the sum bit is still a^b^c; p is only used for carries.
  assign s = a ^ b ^ {c3, c2, c1, ci};

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder16.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder16
//  Description : 16-bit adder split into four 4-bit carry-lookahead stages
//                with valid/ready flow control. Stage registers S0..S3 hold
//                the operand skew; a final output register presents the
//                result, giving acceptance-to-output latency of four edges.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid, in_ready  - operand handshake
//                a, b, cin           - operands and carry in
//                out_valid, out_ready- result handshake
//                sum, cout, ovf      - result, carry out, signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder16
  import cla_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  stage_t            r_stg [NUM_STG];
  stage_t            w_stg_in;
  stage_t            w_slice_out [NUM_STG];
  logic [NIB_W-1:0]  w_slice_s [NUM_STG];
  logic              w_slice_co [NUM_STG];
  logic              w_slice_c3 [NUM_STG];
  logic              w_adv;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_sum;
  logic              r_cout;
  logic              r_ovf;

  // Whole pipe moves as one: it may shift whenever the output slot is empty
  // or is being consumed this cycle.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage k always adds the low nibble of its shifted remainder.
  for (genvar k = 0; k < NUM_STG; k++) begin : g_stage
    cla_slice4 u_slice (
      .a  (r_stg[k].rem_a[NIB_W-1:0]),
      .b  (r_stg[k].rem_b[NIB_W-1:0]),
      .ci (r_stg[k].carry),
      .s  (w_slice_s[k]),
      .co (w_slice_co[k]),
      .c3 (w_slice_c3[k])
    );
  end

  always_comb begin
    w_stg_in = '0;
    if (in_valid) begin
      w_stg_in.valid = 1'b1;
      w_stg_in.carry = cin;
      w_stg_in.rem_a = a;
      w_stg_in.rem_b = b;
    end

    for (int k = 0; k < NUM_STG; k++) begin
      w_slice_out[k] = '0;
      if (r_stg[k].valid) begin
        w_slice_out[k].valid                     = 1'b1;
        w_slice_out[k].psum                      = r_stg[k].psum;
        w_slice_out[k].psum[k*NIB_W +: NIB_W]    = w_slice_s[k];
        w_slice_out[k].carry                     = w_slice_co[k];
        w_slice_out[k].rem_a                     = r_stg[k].rem_a >> NIB_W;
        w_slice_out[k].rem_b                     = r_stg[k].rem_b >> NIB_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STG; k++) begin
        r_stg[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_stg[0] <= w_stg_in;
      for (int k = 1; k < NUM_STG; k++) begin
        r_stg[k] <= w_slice_out[k-1];
      end
      r_out_valid <= w_slice_out[LAST_STG].valid;
      r_sum       <= w_slice_out[LAST_STG].psum;
      r_cout      <= w_slice_out[LAST_STG].carry;
      // Overflow is carry into bit 15 XOR carry out of bit 15, both of which
      // come from the top slice; gated so an empty slot reads as zero.
      r_ovf       <= w_slice_out[LAST_STG].valid
                   & (w_slice_c3[LAST_STG] ^ w_slice_co[LAST_STG]);
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder16
//  Description : Self-checking bench for cla_pipe_adder16. Expected results
//                come from integer arithmetic on the operands, kept in a
//                queue in acceptance order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q [$];

  cla_pipe_adder16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain unsigned and signed integer sums.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    int unsigned u;
    int          sv;
    logic [15:0] s;
    logic        co;
    logic        ov;
    u  = int'(x) + int'(y) + int'(c);
    s  = u[15:0];
    co = (u > 32'd65535);
    sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov = (sv > 32767) || (sv < -32768);
    return {ov, co, s};
  endfunction

  // Advance one clock; record an accepted operand set in the model first.
  task automatic tick();
    if (in_valid && in_ready && !rst) exp_q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL rst_sum: got %h, expected 0000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b, expected 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b, expected 0", ovf); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early(%0d): out_valid got %b, expected 0", t, out_valid); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b, expected 1", out_valid); end
    n_checks++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL lat_sum: got %h, expected 5555", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL lat_cout: got %b, expected 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL lat_ovf: got %b, expected 0", ovf); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_one_cycle: out_valid got %b, expected 0", out_valid); end
    exp_q.delete();
  endtask

  task automatic test_corners();
    logic [15:0] ta [5];
    logic [15:0] tbv [5];
    logic        tc [5];
    logic [15:0] es [5];
    logic        ec [5];
    logic        eo [5];
    int          k;
    ta  = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0FFF};
    tbv = '{16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es  = '{16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 16'h1000};
    ec  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    eo  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 5) begin
        a = ta[c]; b = tbv[c]; cin = tc[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (k >= 5) begin
          n_checks++; n_fail++; $display("FAIL corner_extra: unexpected result sum %h", sum);
        end else begin
          n_checks++; if ({ovf, cout, sum} !== {eo[k], ec[k], es[k]}) begin
            n_fail++;
            $display("FAIL corner(%0d): got ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
                     k, ovf, cout, sum, eo[k], ec[k], es[k]);
          end
        end
        k++;
      end
      tick();
    end
    n_checks++; if (k !== 5) begin n_fail++; $display("FAIL corner_count: got %0d, expected 5", k); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int first;
    int last;
    int cnt;
    logic [17:0] e;
    first = -1; last = -1; cnt = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin rand_ops(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_extra: unexpected result sum %h", sum);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if ({ovf, cout, sum} !== e) begin
            n_fail++; $display("FAIL b2b_data: got %h, expected %h", {ovf, cout, sum}, e);
          end
        end
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      tick();
    end
    n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 8", cnt); end
    n_checks++; if (last - first !== 7) begin n_fail++; $display("FAIL b2b_consecutive: span got %0d, expected 7", last - first); end
  endtask

  task automatic test_stall();
    int drained;
    int fill;
    logic [17:0] e;
    exp_q.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fill = 0;
    while (!out_valid && fill < 10) begin
      rand_ops();
      tick();
      fill++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_fill: out_valid got %b, expected 1", out_valid); end
    for (int s = 0; s < 5; s++) begin
      rand_ops();
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready(%0d): got %b, expected 0", s, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid(%0d): got %b, expected 1", s, out_valid); end
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL stall_model_empty(%0d): no expected result", s);
      end else begin
        n_checks++; if ({ovf, cout, sum} !== exp_q[0]) begin
          n_fail++; $display("FAIL stall_hold(%0d): got %h, expected %h", s, {ovf, cout, sum}, exp_q[0]);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drained   = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL drain_extra: unexpected result sum %h", sum);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if ({ovf, cout, sum} !== e) begin
            n_fail++; $display("FAIL drain_data: got %h, expected %h", {ovf, cout, sum}, e);
          end
        end
        drained++;
      end
      tick();
    end
    n_checks++; if (drained !== 5) begin n_fail++; $display("FAIL drain_count: got %0d, expected 5", drained); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL drain_lost: %0d results never appeared, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_flush();
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    rand_ops();
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, expected 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL flush_sum: got %h, expected 0000", sum); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale(%0d): out_valid got %b, expected 0", c, out_valid); end
    end
  endtask

  task automatic test_random();
    int n_acc;
    int cycles;
    logic [17:0] e;
    n_acc = 0;
    cycles = 0;
    exp_q.delete();
    while ((n_acc < 10000 || exp_q.size() != 0) && cycles < 60000) begin
      in_valid  = (n_acc < 10000) && ($urandom_range(0, 9) < 7);
      rand_ops();
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      n_checks++; if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL rnd_ready: got %b, expected %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rnd_extra: unexpected result sum %h", sum);
        end else begin
          e = exp_q[0];
          n_checks++; if ({ovf, cout, sum} !== e) begin
            n_fail++; $display("FAIL rnd_data: got %h, expected %h", {ovf, cout, sum}, e);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) n_acc++;
      tick();
      cycles++;
    end
    n_checks++; if (cycles >= 60000) begin
      n_fail++; $display("FAIL rnd_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_latency();
    test_corners();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_pipe_adder16.md
CLA_PIPE_ADDER16 -- requirements
Module: cla_pipe_adder16

Interface
REQ-001 Parameters: none; width fixed at 16 bits, 4 stages of 4 bits each.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set on a, b, cin is valid.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 a  input  16  addend A.
REQ-007 b  input  16  addend B.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 out_valid  output  1  sum, cout and ovf hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 sum  output  16  A+B+cin, modulo 2^16.
REQ-012 cout  output  1  carry out of bit 15.
REQ-013 ovf  output  1  signed overflow (carry into bit 15 XOR carry out of bit 15).

Function
REQ-014 A transfer occurs on a rising edge where the valid and ready of the same interface are both high.
REQ-015 Four pipeline stages S0..S3; stage k adds nibble k of A and B with the carry registered from stage k-1 (S0 uses cin).
REQ-016 Each stage holds a valid bit, its completed sum nibbles, the carry out, and the not-yet-added upper nibbles of A and B (operand skew).
REQ-017 Carry within a nibble is computed by 4-bit lookahead: g=a&b, p=a|b, c(i+1)=g(i)|p(i)&c(i), fully expanded with no ripple.
REQ-018 Latency: a result accepted at edge N is presented with out_valid=1 after edge N+4 when there is no stall.
REQ-019 Throughput: one result per cycle while out_ready=1.
REQ-020 Advance enable adv = !out_valid | out_ready; all stages shift together only when adv=1.
REQ-021 in_ready = adv, combinational; in_ready does not depend on in_valid.
REQ-022 When adv=0, every stage holds its contents and sum, cout, ovf and out_valid are stable.
REQ-023 Bubbles (in_valid=0 at an advance) propagate as valid=0 slots; the data in a bubble slot is don't-care, but it is held at 0 for verification determinism.
REQ-024 Results leave in acceptance order; none is dropped or duplicated.
REQ-025 Output stage full with out_ready=0: in_ready=0, and upstream data is not captured.
REQ-026 Simultaneous output drain and input accept in the same cycle: both take effect; occupancy is unchanged.
REQ-027 Wrap-around: 0xFFFF+0x0001+0 gives sum=0x0000, cout=1, ovf=0.

Reset
REQ-028 When rst=1 at an edge, all stage valid bits, data, carries, out_valid, sum, cout and ovf become 0.
REQ-029 Reset takes priority over any transfer in the same cycle; in-flight results are discarded.
REQ-030 The first acceptance is possible on the first edge with rst=0; in_ready=1 during and after reset.

Structure
REQ-031 Shared package cla_pkg holds: NIB_W=4, NUM_STG=4, DATA_W=16, and the stage-record struct (valid, partial sum, carry, remaining A/B).
REQ-032 One sub-module, cla_slice4 (combinational: a[3:0], b[3:0], ci -> s[3:0], co, c3 for overflow), is instantiated once per stage.
REQ-033 No other sub-modules; pipeline registers live in cla_pipe_adder16.

Verification
REQ-034 After reset, apply a=0x1234, b=0x4321, cin=0, out_ready=1 -> exactly 4 edges later: sum=0x5555, cout=0, ovf=0, out_valid=1 for one cycle.
REQ-035 Apply 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; then 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-036 Stream 8 back-to-back operand sets with out_ready=1 -> 8 consecutive out_valid cycles with in-order sums, matching a reference model.
REQ-037 Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable throughout; releasing out_ready drains the results with none lost.
REQ-038 Assert rst with 3 results in flight -> next cycle out_valid=0 and no stale result ever appears.
REQ-039 Random a, b, cin with random in_valid and out_ready, 10k transfers -> every output equals the model's {cout,sum} and ovf, in order.
